// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: reset and lock supervisor for the system PLL on refclk.
// Pulses the PLL reset, waits for lock with a timeout, qualifies lock over a
// stability window before raising pll_ready, restarts the PLL on lock loss and
// parks in FAULT once MAX_RETRIES attempts have timed out.
// Optional build macro: PLL_SEQ_LOSS_COUNT_EN adds the loss_count port and its
// saturating lock-loss counter.
//
// state        | meaning
// S_RESET      | PLL held in reset, RST_CYCLES down-count running
// S_WAIT_LOCK  | PLL released, waiting for synchronised lock
// S_STABLE     | lock seen, counting consecutive locked cycles
// S_RUN        | lock qualified, pll_ready asserted
// S_FAULT      | retries exhausted, PLL held in reset until rst/restart
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                               refclk,
    input  logic                               rst,
    input  logic                               locked,
    input  logic                               restart,
    output logic                               pll_rst,
    output logic                               pll_ready,
    output logic                               pll_fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
`ifdef PLL_SEQ_LOSS_COUNT_EN
    ,
    output logic [7:0]                         loss_count
`endif
);

    localparam int RW  = $clog2(MAX_RETRIES + 1);
    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int TW  = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    // Reset pulse is a down-counter loaded with RST_CYCLES-1 and released at zero.
    localparam logic [RCW-1:0] RST_LOAD  = RCW'(RST_CYCLES - 1);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(LOCK_TIMEOUT);
    // The stable count holds the number of locked cycles already spent in
    // S_STABLE, so completion is taken when it shows STABLE_CYCLES-1.
    localparam logic [SW-1:0]  STB_LAST  = SW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t           state;
    logic             locked_m;
    logic             locked_s;
    logic [RCW-1:0]   rst_cnt;
    logic [TW-1:0]    tmo_cnt;
    logic [SW-1:0]    stb_cnt;
    logic             stb_done;
    logic             tmo_hit;
    logic [RW-1:0]    retry_inc;

    // Completion outranks timeout, so stb_done is tested first in the FSM.
    assign stb_done  = (state == S_STABLE) && locked_s && (stb_cnt == STB_LAST);
    assign tmo_hit   = ((state == S_WAIT_LOCK) || (state == S_STABLE)) && (tmo_cnt == TMO_LAST);
    assign retry_inc = (retry_count == RETRY_MAX) ? retry_count : retry_count + 1'b1;

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge refclk) begin
        if (rst) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= locked;
            locked_s <= locked_m;
        end
    end

    // Sequencer FSM with registered outputs; priority rst > restart > completion > timeout > lock.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= S_RESET;
            rst_cnt     <= RST_LOAD;
            tmo_cnt     <= '0;
            stb_cnt     <= '0;
            retry_count <= '0;
            pll_rst     <= 1'b1;
            pll_ready   <= 1'b0;
            pll_fault   <= 1'b0;
        end else if (restart) begin
            state       <= S_RESET;
            rst_cnt     <= RST_LOAD;
            tmo_cnt     <= '0;
            stb_cnt     <= '0;
            retry_count <= '0;
            pll_rst     <= 1'b1;
            pll_ready   <= 1'b0;
            pll_fault   <= 1'b0;
        end else if (stb_done) begin
            state       <= S_RUN;
            pll_ready   <= 1'b1;
            retry_count <= '0;
        end else if (tmo_hit) begin
            retry_count <= retry_inc;
            rst_cnt     <= RST_LOAD;
            tmo_cnt     <= '0;
            pll_rst     <= 1'b1;
            if (retry_inc == RETRY_MAX) begin
                state     <= S_FAULT;
                pll_fault <= 1'b1;
            end else begin
                state <= S_RESET;
            end
        end else begin
            case (state)
                S_RESET: begin
                    tmo_cnt <= '0;
                    if (rst_cnt == '0) begin
                        state   <= S_WAIT_LOCK;
                        pll_rst <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt - 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (locked_s) begin
                        state   <= S_STABLE;
                        stb_cnt <= '0;
                    end
                end
                S_STABLE: begin
                    // The timeout keeps running across a lock glitch.
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (!locked_s) begin
                        state <= S_WAIT_LOCK;
                    end else begin
                        stb_cnt <= stb_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state     <= S_RESET;
                        rst_cnt   <= RST_LOAD;
                        pll_rst   <= 1'b1;
                        pll_ready <= 1'b0;
                    end
                end
                S_FAULT: begin
                end
                default: begin
                    state     <= S_RESET;
                    rst_cnt   <= RST_LOAD;
                    pll_rst   <= 1'b1;
                    pll_ready <= 1'b0;
                    pll_fault <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_SEQ_LOSS_COUNT_EN
    // Saturating count of RUN exits caused by lock loss; only rst clears it.
    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_count <= '0;
        end else if (!restart && (state == S_RUN) && !locked_s && (loss_count != 8'hFF)) begin
            loss_count <= loss_count + 1'b1;
        end
    end
`else
    // No lock-loss counter in this build.
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: u_a runs default parameters, u_b uses a short
// lock timeout so that retry and fault sequences stay short. Both share stimulus.
module tb_pll_lock_sequencer;

    logic refclk = 1'b0;
    always #5 refclk = ~refclk;

    logic       rst, locked, restart;
    logic       prst_a, ready_a, fault_a;
    logic [1:0] retry_a;
    logic       prst_b, ready_b, fault_b;
    logic [1:0] retry_b;
`ifdef PLL_SEQ_LOSS_COUNT_EN
    logic [7:0] loss_a, loss_b;
`endif

    pll_lock_sequencer u_a (
        .refclk      (refclk),
        .rst         (rst),
        .locked      (locked),
        .restart     (restart),
        .pll_rst     (prst_a),
        .pll_ready   (ready_a),
        .pll_fault   (fault_a),
        .retry_count (retry_a)
`ifdef PLL_SEQ_LOSS_COUNT_EN
        ,
        .loss_count  (loss_a)
`endif
    );

    pll_lock_sequencer #(
        .RST_CYCLES    (16),
        .LOCK_TIMEOUT  (1030),
        .STABLE_CYCLES (1024),
        .MAX_RETRIES   (3)
    ) u_b (
        .refclk      (refclk),
        .rst         (rst),
        .locked      (locked),
        .restart     (restart),
        .pll_rst     (prst_b),
        .pll_ready   (ready_b),
        .pll_fault   (fault_b),
        .retry_count (retry_b)
`ifdef PLL_SEQ_LOSS_COUNT_EN
        ,
        .loss_count  (loss_b)
`endif
    );

    typedef struct {
        string      name;
        bit         sel_b;
        bit         rst;
        bit         locked;
        bit         restart;
        int         len;
        logic       prst;
        logic       ready;
        logic       fault;
        logic [1:0] retry;
    } vec_t;

    typedef struct {
        int         due;
        string      name;
        bit         sel_b;
        logic [4:0] exp;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    int   split;

    function automatic void add(string n, bit b, bit r, bit l, bit rs, int len,
                                logic p, logic rd, logic f, logic [1:0] rt);
        vec_t v;
        v.name = n; v.sel_b = b; v.rst = r; v.locked = l; v.restart = rs;
        v.len = len; v.prst = p; v.ready = rd; v.fault = f; v.retry = rt;
        vecs.push_back(v);
    endfunction

    task automatic cmp_out(string name, logic [4:0] act, logic [4:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: rst/ready/fault/retry got %b required %b",
                     name, cyc, act, exp);
        end
    endtask

    task automatic cmp_int(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0d required %0d", name, cyc, act, exp);
        end
    endtask

    task automatic drain();
        exp_t       e;
        logic [4:0] act;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e   = sb.pop_front();
            act = e.sel_b ? {prst_b, ready_b, fault_b, retry_b}
                          : {prst_a, ready_a, fault_a, retry_a};
            cmp_out(e.name, act, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
        cyc++;
        drain();
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        rst     = v.rst;
        locked  = v.locked;
        restart = v.restart;
        e.due   = cyc + v.len;
        e.name  = v.name;
        e.sel_b = v.sel_b;
        e.exp   = {v.prst, v.ready, v.fault, v.retry};
        sb.push_back(e);
        repeat (v.len) tick();
        drain();
    endtask

    initial begin
        int n;
        rst = 1'b1; locked = 1'b0; restart = 1'b0;

        // Default instance: power-up, first lock, lock loss, glitch in STABLE.
        add("rst_values",       0, 1, 0, 0,    4, 1, 0, 0, 2'd0);
        add("rst_values_b",     1, 1, 0, 0,    0, 1, 0, 0, 2'd0);
        add("pulse_hi",         0, 0, 0, 0,   15, 1, 0, 0, 2'd0);
        add("pulse_fall",       0, 0, 0, 0,    1, 0, 0, 0, 2'd0);
        add("wait_lock",        0, 0, 0, 0,  100, 0, 0, 0, 2'd0);
        add("qual_pre",         0, 0, 1, 0, 1026, 0, 0, 0, 2'd0);
        add("ready_rise",       0, 0, 1, 0,    1, 0, 1, 0, 2'd0);
        add("run_hold",         0, 0, 1, 0,   10, 0, 1, 0, 2'd0);
        add("drop_edge1",       0, 0, 0, 0,    1, 0, 1, 0, 2'd0);
        add("drop_edge2",       0, 0, 1, 0,    1, 0, 1, 0, 2'd0);
        add("drop_edge3",       0, 0, 1, 0,    1, 1, 0, 0, 2'd0);
        add("loss_pulse_hi",    0, 0, 1, 0,   15, 1, 0, 0, 2'd0);
        add("loss_pulse_fall",  0, 0, 1, 0,    1, 0, 0, 0, 2'd0);
        add("stable_pre",       0, 0, 1, 0,  499, 0, 0, 0, 2'd0);
        add("glitch",           0, 0, 0, 0,    1, 0, 0, 0, 2'd0);
        add("requal_pre",       0, 0, 1, 0, 1026, 0, 0, 0, 2'd0);
        add("requal_ready",     0, 0, 1, 0,    1, 0, 1, 0, 2'd0);
        split = vecs.size();
        // Short-timeout instance: three failed attempts, fault, restart.
        add("b_rst",            1, 1, 0, 0,    2, 1, 0, 0, 2'd0);
        add("b_try1_low",       1, 0, 0, 0, 1046, 0, 0, 0, 2'd0);
        add("b_try1_tmo",       1, 0, 0, 0,    1, 1, 0, 0, 2'd1);
        add("b_rst2_hi",        1, 0, 0, 0,   15, 1, 0, 0, 2'd1);
        add("b_rst2_fall",      1, 0, 0, 0,    1, 0, 0, 0, 2'd1);
        add("b_try2_low",       1, 0, 0, 0, 1030, 0, 0, 0, 2'd1);
        add("b_try2_tmo",       1, 0, 0, 0,    1, 1, 0, 0, 2'd2);
        add("b_rst3_hi",        1, 0, 0, 0,   15, 1, 0, 0, 2'd2);
        add("b_rst3_fall",      1, 0, 0, 0,    1, 0, 0, 0, 2'd2);
        add("b_try3_low",       1, 0, 0, 0, 1030, 0, 0, 0, 2'd2);
        add("b_fault",          1, 0, 0, 0,    1, 1, 0, 1, 2'd3);
        add("b_fault_hold",     1, 0, 0, 0,  200, 1, 0, 1, 2'd3);
        add("b_restart",        1, 0, 0, 1,    1, 1, 0, 0, 2'd0);
        add("b_restart_hi",     1, 0, 0, 0,   15, 1, 0, 0, 2'd0);
        add("b_restart_fall",   1, 0, 0, 0,    1, 0, 0, 0, 2'd0);
        // Completion on the exact timeout cycle, then one cycle too late.
        add("c_rst",            1, 1, 0, 0,    2, 1, 0, 0, 2'd0);
        add("c_release",        1, 0, 0, 0,   16, 0, 0, 0, 2'd0);
        add("c_pre_lock",       1, 0, 0, 0,    4, 0, 0, 0, 2'd0);
        add("c_qual_pre",       1, 0, 1, 0, 1026, 0, 0, 0, 2'd0);
        add("c_tie_run",        1, 0, 1, 0,    1, 0, 1, 0, 2'd0);
        add("d_rst",            1, 1, 0, 0,    2, 1, 0, 0, 2'd0);
        add("d_release",        1, 0, 0, 0,   16, 0, 0, 0, 2'd0);
        add("d_pre_lock",       1, 0, 0, 0,    5, 0, 0, 0, 2'd0);
        add("d_qual_pre",       1, 0, 1, 0, 1025, 0, 0, 0, 2'd0);
        add("d_tmo_wins",       1, 0, 1, 0,    1, 1, 0, 0, 2'd1);
        // rst and restart together while waiting for lock with retry_count=1.
        add("e_wait_hi",        1, 0, 0, 0,   15, 1, 0, 0, 2'd1);
        add("e_wait_fall",      1, 0, 0, 0,    1, 0, 0, 0, 2'd1);
        add("e_wait",           1, 0, 0, 0,    5, 0, 0, 0, 2'd1);
        add("e_rst_restart",    1, 1, 0, 1,    1, 1, 0, 0, 2'd0);

        for (int i = 0; i < split; i++) run_vec(vecs[i]);
`ifdef PLL_SEQ_LOSS_COUNT_EN
        cmp_int("loss_after_drop", int'(loss_a), 1);
`endif
        for (int i = split; i < vecs.size(); i++) run_vec(vecs[i]);
`ifdef PLL_SEQ_LOSS_COUNT_EN
        cmp_int("loss_a_cleared", int'(loss_a), 0);
        cmp_int("loss_b_cleared", int'(loss_b), 0);
`endif

        // restart held high: the 16-cycle pulse is measured from its fall.
        rst = 1'b0; restart = 1'b1; locked = 1'b0;
        repeat (5) tick();
        cmp_out("restart_held", {prst_b, ready_b, fault_b, retry_b}, 5'b10000);
        restart = 1'b0;
        n = 0;
        while (prst_b === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        cmp_int("restart_pulse_len", n, 16);
        cmp_out("restart_released", {prst_b, ready_b, fault_b, retry_b}, 5'b00000);

        cmp_int("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
